// File: rtl/conv5x5_filter_pkg.sv
// Shared constants for the 5x5 convolution filter: window geometry, pipeline
// latency, status bit positions, arithmetic widths and the identity-kernel reset value.
package conv_pkg;
  localparam int K      = 5;
  localparam int NTAP   = K * K;
  localparam int LAT    = 6;
  localparam int CENTRE = NTAP / 2;

  localparam int DE = 0;
  localparam int HS = 1;
  localparam int VS = 2;

  localparam int PW = 17;
  localparam int RW = 20;
  localparam int TW = 22;

  function automatic int ident_coef(input int idx, input int rst_shift);
    return (idx == CENTRE) ? (1 << rst_shift) : 0;
  endfunction
endpackage

// File: rtl/conv5x5_filter_channel.sv
// One 8-bit colour channel: 25 products, row sums, total, shift and clamp.
// Four register stages (S1..S4); no backpressure, a result is produced every cycle.
module conv_channel
  import conv_pkg::*;
#(
  parameter int CW = 8,
  parameter int SW = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NTAP-1:0][7:0]      pix,
  input  logic [NTAP-1:0][CW-1:0]   coef,
  input  logic [SW-1:0]             shift,
  output logic [7:0]                result
);

  logic signed [PW-1:0] prod     [NTAP];
  logic signed [PW-1:0] prod_nxt [NTAP];
  logic signed [RW-1:0] rsum     [K];
  logic signed [RW-1:0] rsum_nxt [K];
  logic signed [TW-1:0] total;
  logic signed [TW-1:0] total_nxt;
  logic signed [TW-1:0] shifted;
  logic [SW-1:0]        sh1, sh2, sh3;

  // Pixel is unsigned, so it is zero-extended before the signed multiply.
  function automatic logic signed [PW-1:0] mul(input logic [7:0] p, input logic [CW-1:0] c);
    logic signed [PW-1:0] pe;
    logic signed [PW-1:0] ce;
    pe = PW'(p);
    ce = PW'(signed'(c));
    return pe * ce;
  endfunction

  always_comb begin
    for (int i = 0; i < NTAP; i++) begin
      prod_nxt[i] = mul(pix[i], coef[i]);
    end
    for (int r = 0; r < K; r++) begin
      rsum_nxt[r] = '0;
      for (int k = 0; k < K; k++) begin
        rsum_nxt[r] = rsum_nxt[r] + RW'(prod[r*K+k]);
      end
    end
    total_nxt = '0;
    for (int r = 0; r < K; r++) begin
      total_nxt = total_nxt + TW'(rsum[r]);
    end
    shifted = total >>> sh3;
  end

  // The shift amount travels with the data so every pixel uses one consistent kernel set.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAP; i++) prod[i] <= '0;
      for (int r = 0; r < K; r++)    rsum[r] <= '0;
      total  <= '0;
      sh1    <= '0;
      sh2    <= '0;
      sh3    <= '0;
      result <= '0;
    end else begin
      for (int i = 0; i < NTAP; i++) prod[i] <= prod_nxt[i];
      for (int r = 0; r < K; r++)    rsum[r] <= rsum_nxt[r];
      total <= total_nxt;
      sh1   <= shift;
      sh2   <= sh1;
      sh3   <= sh2;
      if (shifted[TW-1])
        result <= 8'h00;
      else if (|shifted[TW-2:8])
        result <= 8'hFF;
      else
        result <= shifted[7:0];
    end
  end

endmodule

// File: rtl/conv5x5_filter.sv
// 5x5 RGB convolution: window build, de-based column padding, double-buffered kernel.
// Tap on pc at edge n reaches data_o after edge n+6; status is re-aligned; no backpressure.
module conv5x5_filter
  import conv_pkg::*;
#(
  parameter int CW        = 8,
  parameter int SW        = 4,
  parameter int RST_SHIFT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [23:0]   pa,
  input  logic [23:0]   pb,
  input  logic [23:0]   pc,
  input  logic [23:0]   pd,
  input  logic [23:0]   pe,
  input  logic [2:0]    stat_in,
  input  logic          coef_we,
  input  logic [4:0]    coef_addr,
  input  logic [CW-1:0] coef_din,
  input  logic          shift_we,
  input  logic [SW-1:0] shift_din,
  output logic [23:0]   data_o,
  output logic [2:0]    stat_o
);

  logic [K-1:0][23:0]          taps;
  logic [K-1:0][K-1:0][23:0]   win;
  logic [K-1:0]                de_hist;
  logic [LAT:0][2:0]           stat_sr;
  logic [NTAP-1:0][CW-1:0]     shd_coef;
  logic [NTAP-1:0][CW-1:0]     act_coef;
  logic [SW-1:0]               shd_shift;
  logic [SW-1:0]               act_shift;
  logic [2:0][NTAP-1:0][7:0]   pix_m;
  logic [2:0][7:0]             res;
  logic                        vs_rise;

  assign taps    = {pe, pd, pc, pb, pa};
  assign vs_rise = stat_in[VS] & ~stat_sr[0][VS];

  always_ff @(posedge clk) begin
    if (rst) begin
      win     <= '0;
      de_hist <= '0;
      stat_sr <= '0;
      for (int i = 0; i < NTAP; i++) begin
        shd_coef[i] <= CW'(ident_coef(i, RST_SHIFT));
        act_coef[i] <= CW'(ident_coef(i, RST_SHIFT));
      end
      shd_shift <= SW'(RST_SHIFT);
      act_shift <= SW'(RST_SHIFT);
    end else begin
      for (int r = 0; r < K; r++) begin
        win[r] <= {win[r][K-2:0], taps[r]};
      end
      de_hist <= {de_hist[K-2:0], stat_in[DE]};
      stat_sr <= {stat_sr[LAT-1:0], stat_in};
      // Commit takes the shadow as it was before any write landing this same cycle.
      if (vs_rise) begin
        act_coef  <= shd_coef;
        act_shift <= shd_shift;
      end
      if (coef_we && (coef_addr < 5'(NTAP))) begin
        shd_coef[coef_addr] <= coef_din;
      end
      if (shift_we) begin
        shd_shift <= shift_din;
      end
    end
  end

  // Columns outside active video contribute nothing, giving zero padding at line edges.
  always_comb begin
    pix_m = '0;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < K; r++) begin
        for (int k = 0; k < K; k++) begin
          if (de_hist[k]) pix_m[c][r*K+k] = win[r][k][8*c +: 8];
        end
      end
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_ch
    conv_channel #(
      .CW (CW),
      .SW (SW)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .pix    (pix_m[c]),
      .coef   (act_coef),
      .shift  (act_shift),
      .result (res[c])
    );
  end

  assign data_o = res;
  assign stat_o = stat_sr[LAT];

endmodule

// File: tb/tb_conv5x5_filter.sv
// Bench for conv5x5_filter: history-based arithmetic model checked every cycle,
// plus directed scenarios with hand-computed expected pixels.
module tb_conv5x5_filter;
  localparam int CW = 8;
  localparam int SW = 4;
  localparam int RST_SHIFT = 4;
  localparam int MAXE = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic [23:0]   pa, pb, pc, pd, pe;
  logic [2:0]    stat_in;
  logic          coef_we;
  logic [4:0]    coef_addr;
  logic [CW-1:0] coef_din;
  logic          shift_we;
  logic [SW-1:0] shift_din;
  logic [23:0]   data_o;
  logic [2:0]    stat_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv5x5_filter #(.CW(CW), .SW(SW), .RST_SHIFT(RST_SHIFT)) dut (
    .clk(clk), .rst(rst),
    .pa(pa), .pb(pb), .pc(pc), .pd(pd), .pe(pe),
    .stat_in(stat_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_din(coef_din),
    .shift_we(shift_we), .shift_din(shift_din),
    .data_o(data_o), .stat_o(stat_o)
  );

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model state: everything the DUT saw at each clock edge, plus the active kernel after it.
  logic [23:0] h_tap   [MAXE][5];
  logic [2:0]  h_stat  [MAXE];
  bit          h_rst   [MAXE];
  int          h_coef  [MAXE][25];
  int          h_shift [MAXE];
  int          sh_coef [25];
  int          ac_coef [25];
  int          sh_shift, ac_shift;
  int          ecnt = 0;

  function automatic int ident(input int i);
    return (i == 12) ? (1 << RST_SHIFT) : 0;
  endfunction

  function automatic bit any_rst(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (i < 0 || h_rst[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Output after edge e: window as it stood after edge e-4, kernel active at that time.
  function automatic logic [23:0] model_data(input int e);
    logic [23:0] res;
    int m, acc, v;
    res = '0;
    if (any_rst(e - 3, e)) return res;
    m = e - 4;
    if (m < 0) return res;
    for (int c = 0; c < 3; c++) begin
      acc = 0;
      for (int r = 0; r < 5; r++) begin
        for (int k = 0; k < 5; k++) begin
          if (!any_rst(m - k, m) && h_stat[m-k][0])
            acc += int'(h_tap[m-k][r][8*c +: 8]) * h_coef[m][r*5+k];
        end
      end
      v = acc >>> h_shift[m];
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      res[8*c +: 8] = 8'(v);
    end
    return res;
  endfunction

  function automatic logic [2:0] model_stat(input int e);
    if (any_rst(e - 5, e) || e < 6) return 3'b000;
    return h_stat[e-6];
  endfunction

  always @(posedge clk) begin : model
    int  e;
    bit  prev_vs;
    e = ecnt;
    if (e >= MAXE) begin
      $display("FAIL cycle_budget: edge %0d exceeds %0d", e, MAXE);
      $fatal(1, "history exhausted");
    end
    h_rst[e] = rst;
    if (rst) begin
      for (int r = 0; r < 5; r++) h_tap[e][r] = '0;
      h_stat[e] = '0;
      for (int i = 0; i < 25; i++) begin
        sh_coef[i] = ident(i);
        ac_coef[i] = ident(i);
      end
      sh_shift = RST_SHIFT;
      ac_shift = RST_SHIFT;
    end else begin
      h_tap[e][0] = pa; h_tap[e][1] = pb; h_tap[e][2] = pc;
      h_tap[e][3] = pd; h_tap[e][4] = pe;
      h_stat[e] = stat_in;
      prev_vs = (e > 0) ? h_stat[e-1][2] : 1'b0;
      if (stat_in[2] && !prev_vs) begin
        ac_coef  = sh_coef;
        ac_shift = sh_shift;
      end
      if (coef_we && int'(coef_addr) < 25) sh_coef[coef_addr] = int'($signed(coef_din));
      if (shift_we) sh_shift = int'(shift_din);
    end
    h_coef[e]  = ac_coef;
    h_shift[e] = ac_shift;
    ecnt = e + 1;
    #1;
    chk($sformatf("model_data@%0d", e), data_o, model_data(e));
    chk($sformatf("model_stat@%0d", e), 24'(stat_o), 24'(model_stat(e)));
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_taps(input logic [23:0] v);
    pa = v; pb = v; pc = v; pd = v; pe = v;
  endtask

  task automatic rand_taps();
    pa = 24'($urandom); pb = 24'($urandom); pc = 24'($urandom);
    pd = 24'($urandom); pe = 24'($urandom);
  endtask

  task automatic write_all(input int val, input int centre, input int shv);
    for (int a = 0; a < 25; a++) begin
      coef_we   = 1'b1;
      coef_addr = 5'(a);
      coef_din  = CW'((a == 12) ? centre : val);
      cyc();
    end
    coef_we   = 1'b0;
    shift_we  = 1'b1;
    shift_din = SW'(shv);
    cyc();
    shift_we  = 1'b0;
  endtask

  task automatic vs_pulse();
    stat_in = 3'b100;
    cyc();
    stat_in = 3'b000;
  endtask

  logic [23:0] id_pix  [64];
  logic [2:0]  id_stat [64];

  initial begin
    rst = 1'b1; set_taps(24'h0); stat_in = '0;
    coef_we = 1'b0; coef_addr = '0; coef_din = '0;
    shift_we = 1'b0; shift_din = '0;
    repeat (3) cyc();
    chk("reset_data", data_o, 24'h000000);
    chk("reset_stat", 24'(stat_o), 24'h000000);
    rst = 1'b0;

    // Identity kernel straight out of reset
    for (int j = 0; j < 40; j++) begin
      rand_taps();
      pc = {3{8'(j)}};
      stat_in = {1'b0, 1'($urandom), 1'b1};
      id_pix[j]  = pc;
      id_stat[j] = stat_in;
      cyc();
      if (j >= 8 && j % 8 == 0) chk("identity_data", data_o, id_pix[j-6]);
      if (j >= 8 && j % 8 == 1) chk("identity_stat", 24'(stat_o), 24'(id_stat[j-6]));
    end

    // Box kernel loaded mid-frame: output must stay identity until vs rises
    rand_taps(); pc = 24'h123456; stat_in = 3'b001;
    write_all(1, 1, 0);
    chk("commit_hold", data_o, 24'h123456);
    stat_in = 3'b100; coef_we = 1'b1; coef_addr = 5'd12; coef_din = 8'd5;
    cyc();
    coef_we = 1'b0; stat_in = 3'b001; set_taps(24'h0A0A0A);
    repeat (10) cyc();
    chk("box_sum", data_o, 24'hFAFAFA);
    chk("model_box", model_data(ecnt - 1), 24'hFAFAFA);
    vs_pulse();
    stat_in = 3'b001;
    repeat (10) cyc();
    chk("late_write", data_o, 24'hFFFFFF);

    // Border padding with box kernel
    coef_we = 1'b1; coef_addr = 5'd12; coef_din = 8'd1;
    cyc();
    coef_we = 1'b0;
    set_taps(24'h010101);
    vs_pulse();
    stat_in = 3'b000;
    repeat (8) cyc();
    for (int j = 0; j < 10; j++) begin
      stat_in = 3'b001;
      cyc();
      if (j == 6) chk("border_col0", data_o, 24'h0F0F0F);
      if (j == 7) chk("border_col1", data_o, 24'h141414);
      if (j == 8) chk("border_col2", data_o, 24'h191919);
    end

    // Clamp high and low
    write_all(0, 127, 0);
    vs_pulse();
    stat_in = 3'b001; set_taps(24'hFF0100);
    repeat (10) cyc();
    chk("clamp_high", data_o, 24'hFF7F00);
    chk("model_clamp", model_data(ecnt - 1), 24'hFF7F00);
    coef_we = 1'b1; coef_addr = 5'd12; coef_din = 8'hFF;
    cyc();
    coef_we = 1'b0;
    vs_pulse();
    stat_in = 3'b001;
    repeat (10) cyc();
    chk("clamp_low", data_o, 24'h000000);

    // Random traffic, kernel writes (including ignored addresses) and commits
    for (int j = 0; j < 2000; j++) begin
      rand_taps();
      stat_in   = {1'($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom_range(0, 9) != 0)};
      coef_we   = ($urandom_range(0, 3) == 0);
      coef_addr = 5'($urandom);
      coef_din  = ($urandom_range(0, 1) == 1) ? CW'($urandom) : CW'(int'($urandom_range(0, 6)) - 3);
      shift_we  = ($urandom_range(0, 15) == 0);
      shift_din = SW'($urandom);
      cyc();
    end
    coef_we = 1'b0; shift_we = 1'b0;

    // Reset in the middle of active video
    write_all(1, 1, 0);
    vs_pulse();
    stat_in = 3'b001; rand_taps();
    repeat (10) cyc();
    rst = 1'b1;
    cyc();
    chk("midreset_data", data_o, 24'h000000);
    chk("midreset_stat", 24'(stat_o), 24'h000000);
    rst = 1'b0;
    rand_taps(); pc = 24'h5A3C96; stat_in = 3'b001;
    repeat (8) cyc();
    chk("midreset_identity", data_o, 24'h5A3C96);
    chk("midreset_stat_after", 24'(stat_o), 24'h000001);
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv5x5_filter.md
Name: conv5x5_filter

Overview:
- Consumer side of the 5-line delay buffer in the HDMI convolution path.
- Takes the five vertically aligned pixel taps (newest line to oldest line) plus the delayed status bits.
- Builds a 5x5 pixel window, applies a runtime-loadable signed kernel per colour channel, then normalizes and clamps.
- Emits the filtered RGB pixel with status bits re-aligned to it.

Parameters:
- CW, 8, coefficient width (signed two's complement).
- SW, 4, normalization shift width.
- RST_SHIFT, 4, shift value loaded at reset (identity kernel centre = 1<<RST_SHIFT).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- pa  input  24  newest-line pixel {R[23:16],G[15:8],B[7:0]}.
- pb  input  24  line-1 pixel.
- pc  input  24  line-2 pixel (window centre row).
- pd  input  24  line-3 pixel.
- pe  input  24  line-4 pixel.
- stat_in  input  3  {vs[2],hs[1],de[0]}, aligned with the taps.
- coef_we  input  1  coefficient write strobe.
- coef_addr  input  5  kernel index, row*5+col; row 0 = pa, col 0 = newest column.
- coef_din  input  CW  signed coefficient.
- shift_we  input  1  normalization shift write strobe.
- shift_din  input  SW  right-shift amount.
- data_o  output  24  filtered pixel.
- stat_o  output  3  stat_in delayed to match data_o.

Behaviour:
- Clock and reset: single clock domain, clk. rst is synchronous, active-high and applies to every register.
- Reset values:
  - data_o = 0, stat_o = 0.
  - Window, column-de history and all pipeline registers = 0.
  - Shadow and active kernels = identity: coef[12] = 1<<RST_SHIFT, all other coefficients 0, shift = RST_SHIFT.
  - Reset mid-frame discards all in-flight pixels. Output resumes on the first cycle after rst deasserts, with latency as below.
- Window:
  - Every cycle, W[r][0] <= tap r and W[r][k] <= W[r][k-1] for k = 1..4.
  - A parallel 5-bit shift register holds the de bit of each column.
  - Any window column whose de bit = 0 contributes 0 to the sum (zero padding at the left/right borders).
  - No vertical padding: blanking lines arrive black from upstream.
- Pipeline, identical for each channel:
  - S1: 25 products, pixel (8-bit unsigned) x coef (signed) -> 17-bit signed.
  - S2: five row sums, 20-bit signed.
  - S3: total sum, 22-bit signed; no overflow is possible.
  - S4: arithmetic right shift by the active shift (0..15), then clamp to 0..255. Negative results give 0; results above 255 give 255.
- Latency:
  - A pixel sampled on pc at edge n is the window centre W[2][2] after edge n+2.
  - Its filtered value appears on data_o after edge n+6.
  - stat_o = stat_in delayed by exactly 6 registers.
- Kernel double buffering:
  - coef_we writes the shadow kernel at coef_addr; addresses 25..31 are ignored.
  - shift_we writes the shadow shift.
  - Commit: on a vs rising edge (stat_in[2] = 1 this cycle, 0 the previous cycle), the whole shadow set is copied to the active set. The new kernel applies from the next cycle.
  - A write on the same cycle as a commit updates the shadow only. The commit copies the pre-write shadow contents, so that write takes effect at the next frame.
  - The active kernel never changes within a frame.
- Status bits are never altered, only delayed.

Decomposition:
- Package conv_pkg holds:
  - K = 5 and LAT = 6.
  - Status bit indices DE = 0, HS = 1, VS = 2.
  - Product and sum widths (17, 20, 22).
  - The identity-kernel reset constant.
- Sub-module conv_channel: the 8-bit, one-channel multiply/row-sum/total/shift/clamp pipeline (S1..S4). It is instantiated three times for R, G and B.
- The window, de history, kernel banks and status delay live in the top module.

Test Plan:
- Identity after reset:
  - Stimulus: de = 1 constantly; pc = pixel index replicated on all channels, 0x000000, 0x010101, ...
  - Required: data_o equals pc delayed by 6 cycles. stat_o equals stat_in delayed by 6.
- Box sum:
  - Stimulus: load all 25 coefficients = 1 and shift = 0, then pulse vs; all taps = 0x0A0A0A with de = 1.
  - Required: data_o = 0xFAFAFA (250) once the window is full.
- Clamp:
  - Stimulus: centre coefficient = 127, others 0, shift 0, pixel 0xFF0100 → required data_o = 0xFF7F00.
  - Stimulus: centre coefficient = -1 → required data_o = 0x000000.
- Commit timing:
  - Stimulus: write a box kernel mid-frame.
  - Required: output stays identity until the vs rising edge. A coef_we on the exact vs-rise cycle is only visible after the following vs rise.
- Border padding:
  - Stimulus: box kernel, shift 0, pixels 0x010101; de rises at column 0 after blanking.
  - Required: the output for centre column 0 = 15 (3 active columns x 5 rows), column 1 = 20, column 2 = 25.
- Reset mid-frame:
  - Stimulus: assert rst for 1 cycle during active video.
  - Required: data_o = 0 and stat_o = 0 on the next cycle; the identity kernel is restored.
